// File: rtl/rx_phase_search_if.sv
// Bundle between the sampling-phase controller and the receive path.
//
// Signals:
//   i_start        start a phase search (level or pulse)
//   i_error_count  cumulative 64-bit BER error counter (free-running, may wrap)
//   i_bit_count    cumulative 64-bit BER bit counter (free-running, may wrap)
//   o_offset       sampling offset to the RX buffer selector
//   o_rx_enable    enable to the BER/sync block
//   o_busy         search in progress
//   o_locked       search complete, o_offset holds the best phase
//   o_best_errors  error count of the selected phase
//   o_loss         1-cycle loss-of-lock pulse (monitor build only)
//
// Modports:
//   master  the phase-search controller
//   slave   the receive path / environment
interface rx_phase_search_if #(
    parameter int unsigned NB_OFF = 2,
    parameter int unsigned NB_ERR = 32
);
    logic              i_start;
    logic [63:0]       i_error_count;
    logic [63:0]       i_bit_count;
    logic [NB_OFF-1:0] o_offset;
    logic              o_rx_enable;
    logic              o_busy;
    logic              o_locked;
    logic [NB_ERR-1:0] o_best_errors;
    logic              o_loss;

    modport master (
        input  i_start, i_error_count, i_bit_count,
        output o_offset, o_rx_enable, o_busy, o_locked, o_best_errors, o_loss
    );

    modport slave (
        output i_start, i_error_count, i_bit_count,
        input  o_offset, o_rx_enable, o_busy, o_locked, o_best_errors, o_loss
    );
endinterface

// File: rtl/rx_phase_search.sv
// Sampling-phase controller for the PRBS9+BPSK+RC receive path. Sweeps the
// RX sampling offset over all OS phases, measures errors over a WINDOW_BITS
// bit window per phase using the cumulative BER counters, and locks onto the
// phase with the fewest errors (ties keep the lower offset).
//
// Ports:
//   clock  system clock
//   reset  synchronous, active-high reset
//   bus    rx_phase_search_if.master (start, BER counters in; offset,
//          rx enable, busy, locked, best errors, loss out)
//
// Build option:
//   PHASE_SEARCH_MONITOR_EN  when defined, LOCKED keeps measuring windows at
//                            the locked offset and restarts the search with an
//                            o_loss pulse when a window exceeds LOSS_THRESH
//                            errors or times out. Undefined: o_loss is tied 0.
module rx_phase_search #(
    parameter int unsigned OS          = 4,
    parameter int unsigned NB_OFF      = 2,
    parameter int unsigned WINDOW_BITS = 1023,
    parameter int unsigned SETTLE_CYC  = 4096,
    parameter int unsigned TIMEOUT_CYC = 65536,
    parameter int unsigned NB_ERR      = 32,
    parameter int unsigned LOSS_THRESH = 64
) (
    input  logic                clock,
    input  logic                reset,
    rx_phase_search_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_COMPARE,
        S_LOCKED
    } state_t;

    localparam int unsigned CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [63:0]       WINDOW       = 64'(WINDOW_BITS);
    localparam logic [63:0]       ERR_MAX      = (64'd1 << NB_ERR) - 64'd1;
    localparam logic [NB_OFF-1:0] LAST_OFF     = NB_OFF'(OS - 1);

    state_t              state_q, state_d;
    logic [NB_OFF-1:0]   off_q, off_d;
    logic                rx_en_q, rx_en_d;
    logic                busy_q, busy_d;
    logic                locked_q, locked_d;
    logic [NB_ERR-1:0]   best_out_q, best_out_d;
    logic [NB_ERR-1:0]   best_err_q, best_err_d;
    logic [NB_OFF-1:0]   best_off_q, best_off_d;
    logic [63:0]         base_bits_q, base_bits_d;
    logic [63:0]         base_err_q, base_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NB_ERR-1:0]   win_err_q, win_err_d;
`ifdef PHASE_SEARCH_MONITOR_EN
    logic                loss_q, loss_d;
    logic                mon_loss;
`endif

    // Window measurement against the snapshot; modular subtraction makes
    // counter wrap transparent.
    logic [63:0]       d_bits, d_err;
    logic              win_done, cnt_expired, meas_end;
    logic [NB_ERR-1:0] err_sat, meas_err;
    logic              take_new;
    logic [NB_ERR-1:0] best_err_nxt;
    logic [NB_OFF-1:0] best_off_nxt;
    logic              begin_search;

    assign d_bits      = bus.i_bit_count - base_bits_q;
    assign d_err       = bus.i_error_count - base_err_q;
    assign win_done    = (d_bits >= WINDOW);
    assign cnt_expired = (cnt_q == TIMEOUT_LAST);
    assign meas_end    = win_done || cnt_expired;
    assign err_sat     = (d_err > ERR_MAX) ? '1 : d_err[NB_ERR-1:0];
    assign meas_err    = win_done ? err_sat : '1;

    // Strict compare: ties keep the earlier (lower) offset.
    assign take_new     = (win_err_q < best_err_q);
    assign best_err_nxt = take_new ? win_err_q : best_err_q;
    assign best_off_nxt = take_new ? off_q : best_off_q;

`ifdef PHASE_SEARCH_MONITOR_EN
    assign mon_loss = meas_end && (!win_done || (d_err > 64'(LOSS_THRESH)));
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            off_q       <= '0;
            rx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            best_out_q  <= '1;
            best_err_q  <= '1;
            best_off_q  <= '0;
            base_bits_q <= '0;
            base_err_q  <= '0;
            cnt_q       <= '0;
            win_err_q   <= '1;
`ifdef PHASE_SEARCH_MONITOR_EN
            loss_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            rx_en_q     <= rx_en_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            best_out_q  <= best_out_d;
            best_err_q  <= best_err_d;
            best_off_q  <= best_off_d;
            base_bits_q <= base_bits_d;
            base_err_q  <= base_err_d;
            cnt_q       <= cnt_d;
            win_err_q   <= win_err_d;
`ifdef PHASE_SEARCH_MONITOR_EN
            loss_q      <= loss_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.i_start) state_d = S_SETTLE;
            S_SETTLE:  if (cnt_q == SETTLE_LAST) state_d = S_MEASURE;
            S_MEASURE: if (meas_end) state_d = S_COMPARE;
            S_COMPARE: state_d = (off_q == LAST_OFF) ? S_LOCKED : S_SETTLE;
            S_LOCKED: begin
                if (bus.i_start) state_d = S_SETTLE;
`ifdef PHASE_SEARCH_MONITOR_EN
                else if (mon_loss) state_d = S_SETTLE;
`endif
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        off_d        = off_q;
        rx_en_d      = rx_en_q;
        busy_d       = busy_q;
        locked_d     = locked_q;
        best_out_d   = best_out_q;
        best_err_d   = best_err_q;
        best_off_d   = best_off_q;
        base_bits_d  = base_bits_q;
        base_err_d   = base_err_q;
        cnt_d        = cnt_q;
        win_err_d    = win_err_q;
        begin_search = 1'b0;
`ifdef PHASE_SEARCH_MONITOR_EN
        loss_d       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin_search = 1'b1;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    base_bits_d = bus.i_bit_count;
                    base_err_d  = bus.i_error_count;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_MEASURE: begin
                if (meas_end) win_err_d = meas_err;
                else          cnt_d     = cnt_q + 1'b1;
            end
            S_COMPARE: begin
                best_err_d = best_err_nxt;
                best_off_d = best_off_nxt;
                cnt_d      = '0;
                if (off_q != LAST_OFF) begin
                    off_d = off_q + 1'b1;
                end else begin
                    // Uses this cycle's compare result so the last phase can win.
                    off_d      = best_off_nxt;
                    best_out_d = best_err_nxt;
                    busy_d     = 1'b0;
                    locked_d   = 1'b1;
`ifdef PHASE_SEARCH_MONITOR_EN
                    base_bits_d = bus.i_bit_count;
                    base_err_d  = bus.i_error_count;
`endif
                end
            end
            S_LOCKED: begin
                if (bus.i_start) begin
                    begin_search = 1'b1;
                end
`ifdef PHASE_SEARCH_MONITOR_EN
                else if (mon_loss) begin
                    begin_search = 1'b1;
                    loss_d       = 1'b1;
                end else if (meas_end) begin
                    // Window passed: rebase immediately for the next one.
                    base_bits_d = bus.i_bit_count;
                    base_err_d  = bus.i_error_count;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: ;
        endcase

        if (begin_search) begin
            off_d      = '0;
            rx_en_d    = 1'b1;
            busy_d     = 1'b1;
            locked_d   = 1'b0;
            best_err_d = '1;
            best_off_d = '0;
            cnt_d      = '0;
        end
    end

    assign bus.o_offset      = off_q;
    assign bus.o_rx_enable   = rx_en_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_locked      = locked_q;
    assign bus.o_best_errors = best_out_q;
`ifdef PHASE_SEARCH_MONITOR_EN
    assign bus.o_loss        = loss_q;
`else
    assign bus.o_loss        = 1'b0;
`endif

endmodule

// File: tb/tb_rx_phase_search.sv
module tb_rx_phase_search;

    localparam int unsigned S_CYC  = 8;
    localparam int unsigned W_BITS = 1023;
    localparam int unsigned T_CYC  = 200;

    logic clk;
    logic rst;

    rx_phase_search_if #(.NB_OFF(2), .NB_ERR(16)) bus ();

    rx_phase_search #(
        .OS(4),
        .NB_OFF(2),
        .WINDOW_BITS(W_BITS),
        .SETTLE_CYC(S_CYC),
        .TIMEOUT_CYC(T_CYC),
        .NB_ERR(16),
        .LOSS_THRESH(64)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BER counter emulation: bits advance by bpc per cycle (unless the
    // current offset is frozen), errors by the current offset's rate.
    logic [63:0] env_bits = '0;
    logic [63:0] env_errs = '0;
    logic [63:0] bit_bias = '0;
    logic [63:0] err_bias = '0;
    int unsigned bpc;
    logic [63:0] rate [4];
    bit          freeze [4];

    always @(negedge clk) begin
        if (!freeze[bus.o_offset]) env_bits = env_bits + 64'(bpc);
        env_errs = env_errs + rate[bus.o_offset];
    end

    assign bus.i_bit_count   = env_bits + bit_bias;
    assign bus.i_error_count = env_errs + err_bias;

    typedef struct {
        string       tag;
        int unsigned off;
        int unsigned best;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_rates(input logic [63:0] r0, input logic [63:0] r1,
                             input logic [63:0] r2, input logic [63:0] r3);
        rate[0] = r0;
        rate[1] = r1;
        rate[2] = r2;
        rate[3] = r3;
    endtask

    task automatic quiet_link();
        bpc = 1023;
        set_rates(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) freeze[i] = 1'b0;
    endtask

    // Predict the search outcome from the link settings, start the search,
    // and compare against the prediction when the DUT reports lock.
    task automatic run_search(input string tag, input bit poke);
        exp_t        e;
        exp_t        g;
        int unsigned cyc;
        bit          done;
        int unsigned m;
        logic [63:0] w;
        logic [63:0] best;

        e.tag = tag;
        e.off = 0;
        e.lat = 1;
        best  = 64'hFFFF;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bpc == 0 || freeze[i]) begin
                m = T_CYC;
                w = 64'hFFFF;
            end else begin
                m = (W_BITS + bpc - 1) / bpc;
                if (m > T_CYC) begin
                    m = T_CYC;
                    w = 64'hFFFF;
                end else begin
                    w = rate[i] * 64'(m);
                    if (w > 64'hFFFF) w = 64'hFFFF;
                end
            end
            if (w < best) begin
                best  = w;
                e.off = i;
            end
            e.lat += S_CYC + m + 1;
        end
        e.best = best[31:0];
        sb.push_back(e);

        bus.i_start = 1'b1;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                bus.i_start = 1'b0;
                check_eq({tag, "_start_busy"}, 64'(bus.o_busy), 1);
                check_eq({tag, "_start_locked"}, 64'(bus.o_locked), 0);
                check_eq({tag, "_start_off"}, 64'(bus.o_offset), 0);
                check_eq({tag, "_start_rxen"}, 64'(bus.o_rx_enable), 1);
            end
            if (poke && cyc == 30) bus.i_start = 1'b1;
            if (poke && cyc == 31) bus.i_start = 1'b0;
            if (bus.o_locked) done = 1'b1;
        end

        g = sb.pop_front();
        if (!done) begin
            check_eq({g.tag, "_lock_timeout"}, 64'(cyc), 64'(g.lat));
        end else begin
            check_eq({g.tag, "_off"}, 64'(bus.o_offset), 64'(g.off));
            check_eq({g.tag, "_best"}, 64'(bus.o_best_errors), 64'(g.best));
            check_eq({g.tag, "_latency"}, 64'(cyc), 64'(g.lat));
            check_eq({g.tag, "_busy"}, 64'(bus.o_busy), 0);
        end
        quiet_link();
    endtask

    initial begin
        bit found;
        bit seen;

        rst = 1'b1;
        bus.i_start = 1'b0;
        quiet_link();

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_off", 64'(bus.o_offset), 0);
        check_eq("rst_rxen", 64'(bus.o_rx_enable), 0);
        check_eq("rst_busy", 64'(bus.o_busy), 0);
        check_eq("rst_locked", 64'(bus.o_locked), 0);
        check_eq("rst_best", 64'(bus.o_best_errors), 64'hFFFF);
        check_eq("rst_loss", 64'(bus.o_loss), 0);
        rst = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check_eq("idle_busy", 64'(bus.o_busy), 0);
        check_eq("idle_locked", 64'(bus.o_locked), 0);

        // Errors everywhere except offset 2.
        set_rates(10, 10, 0, 10);
        run_search("t1_clean_off2", 1'b0);

        // Equal errors: tie keeps offset 0.
        set_rates(5, 5, 5, 5);
        run_search("t2_tie", 1'b0);

        // Last phase best; stray start pulse mid-search must be ignored.
        set_rates(9, 9, 9, 3);
        run_search("last_wins", 1'b1);

        // 3*341 = 1023 exactly reaches the window; offsets 1 and 2 tie.
        bpc = 341;
        set_rates(4, 2, 2, 7);
        run_search("win_exact", 1'b0);

        // 1022 bits/cycle needs two cycles to reach the window.
        bpc = 1022;
        set_rates(3, 2, 5, 4);
        run_search("win_short", 1'b0);

        // Offset 1 frozen: times out and scores all-ones despite zero errors.
        freeze[1] = 1'b1;
        set_rates(6, 0, 2, 9);
        run_search("t4_timeout", 1'b0);

        // Every phase times out.
        bpc = 0;
        run_search("all_timeout", 1'b0);

        // Saturation: 70000 must clamp to 65535, not truncate.
        set_rates(70000, 70000, 65534, 70000);
        run_search("saturate", 1'b0);

        // Reset during MEASURE of offset 1.
        bpc = 10;
        set_rates(1, 1, 1, 1);
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_offset == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("t5_reach_off1", 64'(found), 1);
        repeat (S_CYC + 10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t5_rst_off", 64'(bus.o_offset), 0);
        check_eq("t5_rst_rxen", 64'(bus.o_rx_enable), 0);
        check_eq("t5_rst_busy", 64'(bus.o_busy), 0);
        check_eq("t5_rst_locked", 64'(bus.o_locked), 0);
        check_eq("t5_rst_best", 64'(bus.o_best_errors), 64'hFFFF);
        check_eq("t5_rst_loss", 64'(bus.o_loss), 0);
        rst = 1'b0;

        // Restart after reset with both counters about to wrap.
        bpc = 100;
        set_rates(2, 1, 0, 2);
        bit_bias = 64'd0 - env_bits - 64'd1500;
        err_bias = 64'd0 - env_errs - 64'd25;
        run_search("t3_wrap", 1'b0);

`ifdef PHASE_SEARCH_MONITOR_EN
        set_rates(50, 50, 50, 1);
        run_search("t6_lock3", 1'b0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.o_loss) seen = 1'b1;
        end
        check_eq("t6_no_loss", 64'(seen), 0);
        check_eq("t6_hold_lock", 64'(bus.o_locked), 1);
        check_eq("t6_hold_best", 64'(bus.o_best_errors), 1);
        rate[3] = 100;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_loss) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("t6_loss_seen", 64'(found), 1);
        check_eq("t6_loss_locked", 64'(bus.o_locked), 0);
        check_eq("t6_loss_off", 64'(bus.o_offset), 0);
        check_eq("t6_loss_busy", 64'(bus.o_busy), 1);
        @(posedge clk);
        #1;
        check_eq("t6_loss_pulse_end", 64'(bus.o_loss), 0);
`else
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.o_loss) seen = 1'b1;
        end
        check_eq("no_loss", 64'(seen), 0);
        check_eq("locked_static", 64'(bus.o_locked), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
